// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle non-restoring integer divider, one quotient bit per clock
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    input  logic                 i_start,
    input  logic                 i_signed_mode,
    input  logic [WIDTH-1:0]     i_dividend,
    input  logic [WIDTH-1:0]     i_divisor,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_div_by_zero,
    output logic [2*WIDTH-1:0]   o_c
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH:0]       r_a;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_m;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;
    logic [2*WIDTH-1:0]   r_c;

    // operand magnitudes; |MIN| wraps to 2^(WIDTH-1), which is correct as an unsigned value
    logic                 w_dvd_neg;
    logic                 w_dvs_neg;
    logic [WIDTH-1:0]     w_dvd_mag;
    logic [WIDTH-1:0]     w_dvs_mag;
    logic                 w_div_zero;

    assign w_dvd_neg  = i_signed_mode & i_dividend[WIDTH-1];
    assign w_dvs_neg  = i_signed_mode & i_divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -i_dividend : i_dividend;
    assign w_dvs_mag  = w_dvs_neg ? -i_divisor : i_divisor;
    assign w_div_zero = (i_divisor == '0);

    // one non-restoring step: shift {a,q} left, then add or subtract m depending on the old sign of a.
    // The shifted partial value may wrap in WIDTH+1 bits, but the post-step value always lies in
    // [-m, m) so the modular result and its sign bit are exact.
    logic [WIDTH:0]       w_m_ext;
    logic [WIDTH:0]       w_a_sh;
    logic [WIDTH:0]       w_a_step;
    logic                 w_last;

    assign w_m_ext  = {1'b0, r_m};
    assign w_a_sh   = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_a_step = r_a[WIDTH] ? (w_a_sh + w_m_ext) : (w_a_sh - w_m_ext);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // final correction: restore a negative remainder, then apply the recorded signs
    logic [WIDTH:0]       w_a_fix;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_m_zero;

    assign w_a_fix  = r_a[WIDTH] ? (r_a + w_m_ext) : r_a;
    assign w_quot   = r_neg_q ? -r_q : r_q;
    assign w_rem    = r_neg_r ? -w_a_fix[WIDTH-1:0] : w_a_fix[WIDTH-1:0];
    // a zero m only occurs for a zero divisor, since every non-zero divisor has a non-zero magnitude
    assign w_m_zero = (r_m == '0);

    // control FSM and datapath registers; clr aborts any operation in flight
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_c     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a    <= '0;
                        r_cnt  <= '0;
                        r_dbz  <= 1'b0;
                        r_busy <= 1'b1;
                        if (w_div_zero) begin
                            // keep the raw dividend in q so it can be returned as the remainder
                            r_q     <= i_dividend;
                            r_m     <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= S_FIX;
                        end else begin
                            r_q     <= w_dvd_mag;
                            r_m     <= w_dvs_mag;
                            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r <= w_dvd_neg;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_step;
                    r_q   <= {r_q[WIDTH-2:0], ~w_a_step[WIDTH]};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (w_m_zero) begin
                        r_c   <= {r_q, {WIDTH{1'b1}}};
                        r_dbz <= 1'b1;
                    end else begin
                        r_c <= {w_rem, w_quot};
                        r_a <= w_a_fix;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_c           = r_c;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard testbench for seq_divider at WIDTH=32 and WIDTH=8
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        clr = 1'b1;

    logic        s32 = 1'b0, sm32 = 1'b0;
    logic [31:0] dd32 = '0, dv32 = '0;
    logic        busy32, done32, dbz32;
    logic [63:0] c32;

    logic        s8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  dd8 = '0, dv8 = '0;
    logic        busy8, done8, dbz8;
    logic [15:0] c8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] c;
        logic        dbz;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    seq_divider #(.WIDTH(32)) u_div32 (
        .i_clk(clk), .i_clr(clr), .i_start(s32), .i_signed_mode(sm32),
        .i_dividend(dd32), .i_divisor(dv32),
        .o_busy(busy32), .o_done(done32), .o_div_by_zero(dbz32), .o_c(c32)
    );

    seq_divider #(.WIDTH(8)) u_div8 (
        .i_clk(clk), .i_clr(clr), .i_start(s8), .i_signed_mode(sm8),
        .i_dividend(dd8), .i_divisor(dv8),
        .o_busy(busy8), .o_done(done8), .o_div_by_zero(dbz8), .o_c(c8)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [63:0] c, input logic dbz);
        exp_t e;
        e.c   = c;
        e.dbz = dbz;
        return e;
    endfunction

    // reference model using 64-bit arithmetic: returns {remainder, quotient} packed at width w
    function automatic logic [63:0] model(input int w, input logic sm,
                                          input logic [31:0] a, input logic [31:0] b);
        longint mask, sa, sb, qq, rr;
        mask = (longint'(1) << w) - 1;
        sa = longint'({32'b0, a}) & mask;
        sb = longint'({32'b0, b}) & mask;
        if (sb == 0) return 64'((sa << w) | mask);
        if (sm) begin
            if (sa[w-1]) sa = sa - (longint'(1) << w);
            if (sb[w-1]) sb = sb - (longint'(1) << w);
        end
        qq = sa / sb;
        rr = sa % sb;
        return 64'(((rr & mask) << w) | (qq & mask));
    endfunction

    task automatic start32(input logic sm, input logic [31:0] a, input logic [31:0] b);
        s32 = 1'b1; sm32 = sm; dd32 = a; dv32 = b;
        @(posedge clk); #1;
        s32 = 1'b0; sm32 = 1'($urandom); dd32 = $urandom; dv32 = $urandom;
    endtask

    task automatic start8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        s8 = 1'b1; sm8 = sm; dd8 = a; dv8 = b;
        @(posedge clk); #1;
        s8 = 1'b0; sm8 = 1'($urandom); dd8 = 8'($urandom); dv8 = 8'($urandom);
    endtask

    // waits (bounded) for done; cyc = edges from acceptance to done, bcnt = samples with busy high
    task automatic wait32(output int cyc, output int bcnt);
        bcnt = busy32 ? 1 : 0;
        cyc  = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done32) break;
            if (busy32) bcnt++;
        end
    endtask

    task automatic wait8(output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done8) break;
        end
    endtask

    task automatic test_reset;
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy32, done32, dbz32} !== 3'b000) begin errors++; $display("FAIL reset32_flags: got %b expected 000", {busy32, done32, dbz32}); end
        checks++; if (c32 !== 64'd0) begin errors++; $display("FAIL reset32_c: got %h expected 0", c32); end
        checks++; if ({busy8, done8, dbz8, c8} !== 19'd0) begin errors++; $display("FAIL reset8: got %h expected 0", {busy8, done8, dbz8, c8}); end
        clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_basic;
        int cyc, bcnt;
        exp_t e;
        start32(1'b0, 32'd100, 32'd7);
        q32.push_back(mk({32'd2, 32'd14}, 1'b0));
        checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", busy32); end
        wait32(cyc, bcnt);
        checks++; if (cyc != 33) begin errors++; $display("FAIL basic_latency: got %0d expected 33", cyc); end
        checks++; if (bcnt != 33) begin errors++; $display("FAIL basic_busy_len: got %0d expected 33", bcnt); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", busy32); end
        if (q32.size() == 0) begin checks++; errors++; $display("FAIL basic_queue: got empty expected entry"); end
        else begin
            e = q32.pop_front();
            checks++; if (c32 !== e.c) begin errors++; $display("FAIL basic_c: got %h expected %h", c32, e.c); end
            checks++; if (dbz32 !== e.dbz) begin errors++; $display("FAIL basic_dbz: got %b expected %b", dbz32, e.dbz); end
        end
        @(posedge clk); #1;
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done32); end
        checks++; if (c32 !== {32'd2, 32'd14}) begin errors++; $display("FAIL basic_c_hold: got %h expected %h", c32, {32'd2, 32'd14}); end
    endtask

    task automatic test_signed;
        logic        sm_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] a_t  [4] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'h80000000};
        logic [31:0] b_t  [4] = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF};
        logic [63:0] r_t  [4] = '{{32'hFFFFFFFE, 32'hFFFFFFF2}, {32'd2, 32'hFFFFFFF2},
                                  {32'd2, 32'h24924916}, {32'd0, 32'h80000000}};
        int cyc, bcnt;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            start32(sm_t[i], a_t[i], b_t[i]);
            q32.push_back(mk(r_t[i], 1'b0));
            wait32(cyc, bcnt);
            if (q32.size() == 0) begin checks++; errors++; $display("FAIL signed_queue[%0d]: got empty expected entry", i); end
            else begin
                e = q32.pop_front();
                checks++; if (c32 !== e.c) begin errors++; $display("FAIL signed_c[%0d]: got %h expected %h", i, c32, e.c); end
                checks++; if (dbz32 !== e.dbz) begin errors++; $display("FAIL signed_dbz[%0d]: got %b expected %b", i, dbz32, e.dbz); end
            end
            checks++; if (cyc != 33) begin errors++; $display("FAIL signed_latency[%0d]: got %0d expected 33", i, cyc); end
        end
    endtask

    task automatic test_div_by_zero;
        int cyc, bcnt;
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            start32(1'(m), 32'h1234, 32'd0);
            q32.push_back(mk({32'h1234, 32'hFFFFFFFF}, 1'b1));
            wait32(cyc, bcnt);
            checks++; if (cyc != 1) begin errors++; $display("FAIL dbz_latency[%0d]: got %0d expected 1", m, cyc); end
            if (q32.size() == 0) begin checks++; errors++; $display("FAIL dbz_queue[%0d]: got empty expected entry", m); end
            else begin
                e = q32.pop_front();
                checks++; if (c32 !== e.c) begin errors++; $display("FAIL dbz_c[%0d]: got %h expected %h", m, c32, e.c); end
                checks++; if (dbz32 !== e.dbz) begin errors++; $display("FAIL dbz_flag[%0d]: got %b expected %b", m, dbz32, e.dbz); end
            end
            repeat (3) @(posedge clk);
            #1;
            checks++; if (dbz32 !== 1'b1) begin errors++; $display("FAIL dbz_hold[%0d]: got %b expected 1", m, dbz32); end
        end
        start32(1'b0, 32'd1000, 32'd10);
        q32.push_back(mk({32'd0, 32'd100}, 1'b0));
        checks++; if (dbz32 !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b expected 0", dbz32); end
        wait32(cyc, bcnt);
        if (q32.size() == 0) begin checks++; errors++; $display("FAIL dbz_next_queue: got empty expected entry"); end
        else begin
            e = q32.pop_front();
            checks++; if (c32 !== e.c) begin errors++; $display("FAIL dbz_next_c: got %h expected %h", c32, e.c); end
        end
    endtask

    task automatic test_ignore_start;
        int cyc, bcnt;
        exp_t e;
        start32(1'b0, 32'd5000, 32'd3);
        q32.push_back(mk(model(32, 1'b0, 32'd5000, 32'd3), 1'b0));
        repeat (9) @(posedge clk);
        #1;
        s32 = 1'b1; sm32 = 1'b1; dd32 = 32'hDEAD0000; dv32 = 32'd17;
        @(posedge clk); #1;
        s32 = 1'b0;
        wait32(cyc, bcnt);
        checks++; if (cyc + 10 != 33) begin errors++; $display("FAIL ignore_latency: got %0d expected 33", cyc + 10); end
        if (q32.size() == 0) begin checks++; errors++; $display("FAIL ignore_queue: got empty expected entry"); end
        else begin
            e = q32.pop_front();
            checks++; if (c32 !== e.c) begin errors++; $display("FAIL ignore_c: got %h expected %h", c32, e.c); end
        end
        @(posedge clk); #1;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL ignore_no_queueing: got busy %b expected 0", busy32); end
    endtask

    task automatic test_back_to_back;
        int cyc, bcnt;
        exp_t e;
        s32 = 1'b1; sm32 = 1'b1; dd32 = 32'hFFFF0000; dv32 = 32'd9;
        q32.push_back(mk(model(32, 1'b1, 32'hFFFF0000, 32'd9), 1'b0));
        @(posedge clk); #1;
        sm32 = 1'b0; dd32 = 32'd77777; dv32 = 32'd123;
        q32.push_back(mk(model(32, 1'b0, 32'd77777, 32'd123), 1'b0));
        wait32(cyc, bcnt);
        checks++; if (cyc != 33) begin errors++; $display("FAIL b2b_latency1: got %0d expected 33", cyc); end
        if (q32.size() == 0) begin checks++; errors++; $display("FAIL b2b_queue1: got empty expected entry"); end
        else begin
            e = q32.pop_front();
            checks++; if (c32 !== e.c) begin errors++; $display("FAIL b2b_c1: got %h expected %h", c32, e.c); end
        end
        @(posedge clk); #1;
        s32 = 1'b0;
        checks++; if ({busy32, done32} !== 2'b10) begin errors++; $display("FAIL b2b_accept: got %b expected 10", {busy32, done32}); end
        wait32(cyc, bcnt);
        checks++; if (cyc != 33) begin errors++; $display("FAIL b2b_latency2: got %0d expected 33", cyc); end
        if (q32.size() == 0) begin checks++; errors++; $display("FAIL b2b_queue2: got empty expected entry"); end
        else begin
            e = q32.pop_front();
            checks++; if (c32 !== e.c) begin errors++; $display("FAIL b2b_c2: got %h expected %h", c32, e.c); end
        end
    endtask

    task automatic test_clr_abort;
        int cyc, bcnt;
        bit seen;
        exp_t e;
        start32(1'b1, 32'h7FFF1234, 32'd5);
        repeat (14) @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        checks++; if ({busy32, done32, dbz32} !== 3'b000) begin errors++; $display("FAIL clr_flags: got %b expected 000", {busy32, done32, dbz32}); end
        checks++; if (c32 !== 64'd0) begin errors++; $display("FAIL clr_c: got %h expected 0", c32); end
        @(posedge clk); #1;
        clr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done32 || busy32) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL clr_no_done: got activity expected none"); end
        start32(1'b1, 32'hFFFFFC18, 32'd33);
        q32.push_back(mk(model(32, 1'b1, 32'hFFFFFC18, 32'd33), 1'b0));
        wait32(cyc, bcnt);
        checks++; if (cyc != 33) begin errors++; $display("FAIL clr_next_latency: got %0d expected 33", cyc); end
        if (q32.size() == 0) begin checks++; errors++; $display("FAIL clr_next_queue: got empty expected entry"); end
        else begin
            e = q32.pop_front();
            checks++; if (c32 !== e.c) begin errors++; $display("FAIL clr_next_c: got %h expected %h", c32, e.c); end
        end
    endtask

    task automatic test_random32;
        int cyc, bcnt;
        logic        sm;
        logic [31:0] a, b;
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            sm = 1'($urandom);
            a  = $urandom;
            case (i % 6)
                0:       b = 32'($urandom_range(1, 15));
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'h80000000;
                3:       b = (i == 9) ? 32'd0 : {16'd0, 16'($urandom)};
                default: b = $urandom;
            endcase
            if (i == 4) a = 32'h80000000;
            start32(sm, a, b);
            q32.push_back(mk(model(32, sm, a, b), b == 32'd0));
            wait32(cyc, bcnt);
            if (q32.size() == 0) begin checks++; errors++; $display("FAIL rand32_queue[%0d]: got empty expected entry", i); end
            else begin
                e = q32.pop_front();
                checks++; if (c32 !== e.c) begin errors++; $display("FAIL rand32_c[%0d]: sm=%b %h/%h got %h expected %h", i, sm, a, b, c32, e.c); end
                checks++; if (dbz32 !== e.dbz) begin errors++; $display("FAIL rand32_dbz[%0d]: got %b expected %b", i, dbz32, e.dbz); end
            end
        end
    endtask

    task automatic test_width8;
        int cyc;
        logic       sm;
        logic [7:0] a, b;
        exp_t e;
        start8(1'b0, 8'd200, 8'd3);
        q8.push_back(mk({48'd0, 8'd2, 8'd66}, 1'b0));
        wait8(cyc);
        checks++; if (cyc != 9) begin errors++; $display("FAIL w8_latency: got %0d expected 9", cyc); end
        if (q8.size() == 0) begin checks++; errors++; $display("FAIL w8_queue: got empty expected entry"); end
        else begin
            e = q8.pop_front();
            checks++; if (c8 !== e.c[15:0]) begin errors++; $display("FAIL w8_unsigned: got %h expected %h", c8, e.c[15:0]); end
        end
        start8(1'b1, 8'h80, 8'h03);
        q8.push_back(mk({48'd0, 8'hFE, 8'hD6}, 1'b0));
        wait8(cyc);
        if (q8.size() == 0) begin checks++; errors++; $display("FAIL w8_queue_s: got empty expected entry"); end
        else begin
            e = q8.pop_front();
            checks++; if (c8 !== e.c[15:0]) begin errors++; $display("FAIL w8_signed: got %h expected %h", c8, e.c[15:0]); end
        end
        for (int i = 0; i < 16; i++) begin
            sm = 1'($urandom);
            a  = 8'($urandom);
            b  = (i == 5) ? 8'd0 : 8'($urandom);
            start8(sm, a, b);
            q8.push_back(mk(model(8, sm, {24'd0, a}, {24'd0, b}), b == 8'd0));
            wait8(cyc);
            if (q8.size() == 0) begin checks++; errors++; $display("FAIL rand8_queue[%0d]: got empty expected entry", i); end
            else begin
                e = q8.pop_front();
                checks++; if (c8 !== e.c[15:0]) begin errors++; $display("FAIL rand8_c[%0d]: sm=%b %h/%h got %h expected %h", i, sm, a, b, c8, e.c[15:0]); end
                checks++; if (dbz8 !== e.dbz) begin errors++; $display("FAIL rand8_dbz[%0d]: got %b expected %b", i, dbz8, e.dbz); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_basic;
        test_signed;
        test_div_by_zero;
        test_ignore_start;
        test_back_to_back;
        test_clr_abort;
        test_random32;
        test_width8;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
